// File: rtl/fu_dispatcher_pkg.sv
// Shared definitions for the IoT filtering front end: function codes,
// issuer state encoding and default datapath widths.
package fu_dispatcher_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int BYTE_W_DEF = 8;

  // Function codes carried on fn_sel / fu_fn; FnNone is never answered by a unit.
  typedef enum logic [2:0] {
    FnNone    = 3'd0,
    Bin2Gray  = 3'd1,
    Gray2Bin  = 3'd2,
    FnMedian  = 3'd3,
    FnThresh  = 3'd4,
    FnDelta   = 3'd5
  } fn_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StOut
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// Collects BYTE_W-bit samples into one DATA_W word, first byte in the top lane.
// With FU_DISPATCH_SKID_EN a completed word can wait in a pending buffer.
module byte_packer
  import fu_dispatcher_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [BYTE_W-1:0] i_byte,
  input  logic [2:0]        i_fn,
  input  logic              i_issuer_free,
  output logic              o_ready,
  output logic              o_avail,
  output logic [DATA_W-1:0] o_word,
  output logic [2:0]        o_fn
);

  localparam int LANES   = DATA_W / BYTE_W;
  localparam int CNT_W   = $clog2(LANES);
  localparam int LANES_W = DATA_W - BYTE_W;

  logic [CNT_W-1:0]   r_cnt;
  logic [LANES_W-1:0] r_lanes;
  logic [2:0]         r_fn;

  logic               w_accept;
  logic               w_last;
  logic [DATA_W-1:0]  w_word;
  logic [2:0]         w_fn;

  // The final byte is never stored: it completes the word combinationally.
  assign w_accept = i_en && o_ready;
  assign w_last   = w_accept && (r_cnt == CNT_W'(LANES - 1));
  assign w_word   = {r_lanes, i_byte};
  assign w_fn     = (r_cnt == '0) ? i_fn : r_fn;

  // NOTE: the lane buffer is reset too, so a word cut short by reset never leaks into fu_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_lanes <= '0;
      r_fn    <= '0;
    end else if (w_accept) begin
      r_lanes <= {r_lanes[LANES_W-BYTE_W-1:0], i_byte};
      if (r_cnt == '0) r_fn <= i_fn;
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

`ifdef FU_DISPATCH_SKID_EN
  logic              r_pending;
  logic [DATA_W-1:0] r_buf;
  logic [2:0]        r_buf_fn;
  logic              w_take;

  assign o_ready = !r_pending;
  assign o_avail = r_pending || w_last;
  assign w_take  = i_issuer_free && o_avail;
  assign o_word  = r_pending ? r_buf : w_word;
  assign o_fn    = r_pending ? r_buf_fn : w_fn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_buf     <= '0;
      r_buf_fn  <= '0;
    end else if (w_last && !w_take) begin
      r_pending <= 1'b1;
      r_buf     <= w_word;
      r_buf_fn  <= w_fn;
    end else if (w_take) begin
      r_pending <= 1'b0;
    end
  end
`else
  assign o_ready = i_issuer_free;
  assign o_avail = w_last;
  assign o_word  = w_word;
  assign o_fn    = w_fn;
`endif

endmodule

// File: rtl/fu_dispatcher.sv
// Packs the sensor byte stream into words, issues each to a function unit and
// returns its result; a watchdog aborts unanswered issues. Option: FU_DISPATCH_SKID_EN.
module fu_dispatcher
  import fu_dispatcher_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BYTE_W  = BYTE_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_en,
  input  logic [BYTE_W-1:0] iot_in,
  input  logic [2:0]        fn_sel,
  output logic              in_ready,
  output logic              fu_en,
  output logic [2:0]        fu_fn,
  output logic [DATA_W-1:0] fu_data,
  input  logic [DATA_W-1:0] fu_result,
  input  logic              fu_valid,
  output logic [DATA_W-1:0] iot_out,
  output logic              valid,
  output logic              err
);

  state_e            r_state;
  logic [15:0]       r_wd;
  logic              r_fu_en;
  logic [2:0]        r_fu_fn;
  logic [DATA_W-1:0] r_fu_data;
  logic [DATA_W-1:0] r_iot_out;
  logic              r_valid;
  logic              r_err;

  logic              w_free;
  logic              w_avail;
  logic              w_take;
  logic [DATA_W-1:0] w_word;
  logic [2:0]        w_fn;

`ifdef FU_DISPATCH_SKID_EN
  assign w_free = (r_state == StIdle) || (r_state == StOut);
`else
  assign w_free = (r_state == StIdle);
`endif
  assign w_take = w_free && w_avail;

  byte_packer #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W)
  ) u_packer (
    .clk           (clk),
    .rst           (rst),
    .i_en          (in_en),
    .i_byte        (iot_in),
    .i_fn          (fn_sel),
    .i_issuer_free (w_free),
    .o_ready       (in_ready),
    .o_avail       (w_avail),
    .o_word        (w_word),
    .o_fn          (w_fn)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_wd      <= '0;
      r_fu_en   <= 1'b0;
      r_fu_fn   <= '0;
      r_fu_data <= '0;
      r_iot_out <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here with <=, so each branch only raises what it needs.
      r_fu_en <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        StIdle, StOut: begin
          if (w_take) begin
            r_state   <= StIssue;
            r_fu_en   <= 1'b1;
            r_fu_fn   <= w_fn;
            r_fu_data <= w_word;
          end else begin
            r_state <= StIdle;
          end
        end
        StIssue: begin
          r_state <= StWait;
          r_wd    <= '0;
        end
        StWait: begin
          // A result arriving on the timeout cycle still counts.
          if (fu_valid) begin
            r_iot_out <= fu_result;
            r_valid   <= 1'b1;
            r_state   <= StOut;
          end else if (r_wd == 16'(TIMEOUT)) begin
            r_err   <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_wd <= r_wd + 16'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign fu_en   = r_fu_en;
  assign fu_fn   = r_fu_fn;
  assign fu_data = r_fu_data;
  assign iot_out = r_iot_out;
  assign valid   = r_valid;
  assign err     = r_err;

endmodule
